melody_arbiter: RTL



---
 rtl/melody_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/melody_arbiter.sv
// Shares one note-to-buzzer path among keyboard, auto-play and learn sources.
// Fixed priority, ownership lock, optional preemption, forced silent gap.
module melody_arbiter #(
  parameter int NOTE_W  = 5,
  parameter int GAP_CYC = 16,
  parameter int PREEMPT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mute,
  input  logic [2:0]        req,
  input  logic [NOTE_W-1:0] note0,
  input  logic [NOTE_W-1:0] note1,
  input  logic [NOTE_W-1:0] note2,
  output logic [NOTE_W-1:0] note_out,
  output logic [2:0]        grant,
  output logic              busy,
  output logic              in_gap
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_e;

  localparam logic [15:0] GAP_LD = 16'(GAP_CYC - 1);

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [2:0] first;
  logic [2:0] higher;
  logic       hold;

  // Lowest set bit wins; higher holds requests above the owner.
  assign first  = req & (~req + 3'd1);
  assign higher = req & (grant_q - 3'd1);
  assign hold   = |(req & grant_q);

  function automatic logic [NOTE_W-1:0] pick(
    input logic [2:0] oh,
    input logic [NOTE_W-1:0] n0,
    input logic [NOTE_W-1:0] n1,
    input logic [NOTE_W-1:0] n2
  );
    return ({NOTE_W{oh[0]}} & n0) |
           ({NOTE_W{oh[1]}} & n1) |
           ({NOTE_W{oh[2]}} & n2);
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    note_d  = '0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_d = OWN;
            grant_d = first;
            note_d  = pick(first, note0, note1, note2);
          end
        end
        OWN: begin
          if (!hold || (PREEMPT != 0 && |higher)) begin
            state_d = GAP;
            grant_d = '0;
            cnt_d   = GAP_LD;
          end else begin
            note_d = pick(grant_q, note0, note1, note2);
          end
        end
        GAP: begin
          if (cnt_q == 16'd0) begin
            if (|req) begin
              state_d = OWN;
              grant_d = first;
              note_d  = pick(first, note0, note1, note2);
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
      if (mute) note_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      note_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
    end
  end

  assign note_out = note_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign in_gap   = (state_q == GAP);

endmodule
